// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add step per clock, LSB first, with a single carry flop.
// sum/cout are registered and only update when the last bit has been processed.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_s;
  logic             carry_n;
  logic             load;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_n = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    case (state_q)
      IDLE: begin
        if (start) load = 1'b1;
      end
      RUN: begin
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = carry_n;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = carry_n;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) load = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Loading is shared by IDLE and DONE so back-to-back starts skip IDLE.
    if (load) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      res_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One addition: accept on E0, bits on E1..E8, done visible right after E8.
  // hold keeps start high throughout; noise scrambles operands and start while busy.
  task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic c_v,
                        input bit noise, input bit hold);
    logic [W:0] total;
    total = {1'b0, a_v} + {1'b0, b_v} + {{W{1'b0}}, c_v};
    start = 1'b1;
    a     = a_v;
    b     = b_v;
    cin   = c_v;
    @(posedge clk); #1;
    start = hold;
    if (noise) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
    end
    for (int unsigned k = 1; k <= W; k++) begin
      if (noise && k < W) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        if (!hold) start = 1'($urandom);
      end
      if (k == W && !hold) start = 1'b0;
      @(posedge clk); #1;
      if (k < W) begin
        check("busy_run", 32'(busy), 32'd1);
        check("done_run", 32'(done), 32'd0);
        check("sum_held", 32'(sum), 32'(exp_sum));
        check("cout_held", 32'(cout), 32'(exp_cout));
      end else begin
        exp_sum  = total[W-1:0];
        exp_cout = total[W];
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(exp_sum));
        check("cout", 32'(cout), 32'(exp_cout));
      end
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    start = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("done_idle", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("sum_idle", 32'(sum), 32'(exp_sum));
      check("cout_idle", 32'(cout), 32'(exp_cout));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2);

    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle_cycles(3);
    run_op(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
    idle_cycles(1);

    for (int unsigned i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b1);
    idle_cycles(1);

    // Abort mid-run: reset lands between edges while bit 4 is pending.
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    a = 8'h77; b = 8'h11; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    exp_sum  = '0;
    exp_cout = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    check("rst_start_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(10);
    run_op(8'h77, 8'h11, 1'b0, 1'b0, 1'b0);

    for (int unsigned i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the operand and sum width in bits (legal range 2..32).
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  Reset SHALL be asynchronous and active-low.
REQ-004 start  input  1  Request a new addition; sampled on the rising edge.
REQ-005 a  input  WIDTH  Augend; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  Addend; sampled only on the edge that accepts start.
REQ-007 cin  input  1  Carry-in; sampled only on the edge that accepts start.
REQ-008 busy  output  1  High while an addition is in progress.
REQ-009 done  output  1  One-cycle pulse: sum and cout hold a new result.
REQ-010 sum  output  WIDTH  Result, a + b + cin modulo 2^WIDTH.
REQ-011 cout  output  1  Carry-out of the WIDTH-bit addition.

Function
REQ-012 The block SHALL be bit-serial, with one full-add step per clock, LSB first, using a single carry flip-flop and operand shift registers; it SHALL NOT contain a WIDTH-bit parallel adder.
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE. Each output SHALL be a function of registered state only.
REQ-014 IDLE, start=1: the edge SHALL load a, b into shift registers, load the carry flop with cin, clear the bit counter, and go to RUN.
REQ-015 IDLE, start=0: the FSM SHALL stay in IDLE.
REQ-016 RUN, each edge: it SHALL compute s = a0^b0^c and c' = a0&b0 | c&(a0^b0), shift s into the internal result register from the MSB end, shift the operands right by one, update carry, and increment the counter.
REQ-017 RUN exit: on the edge processing bit WIDTH-1, the FSM SHALL copy the internal result to sum, copy the final carry to cout, and go to DONE.
REQ-018 Latency: with start accepted on edge E0, bits are processed on edges E1..E_WIDTH, and done SHALL be high for exactly the cycle between E_WIDTH and E_WIDTH+1.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE. done SHALL be 1 only in DONE.
REQ-020 start while busy=1 SHALL be ignored: no reload, no queueing, and the in-flight result is unaffected.
REQ-021 DONE, start=1: the block SHALL behave as in REQ-014 (load and go to RUN), allowing back-to-back operations with no IDLE cycle.
REQ-022 DONE, start=0: the FSM SHALL go to IDLE.
REQ-023 sum and cout SHALL change only on the REQ-017 edge and SHALL hold their value through IDLE and through later RUN phases until the next completion.
REQ-024 Changes on a, b, cin after acceptance SHALL NOT affect the result.
REQ-025 Carry arithmetic SHALL match {cout,sum} = a + b + cin, computed at WIDTH+1 bits, for all operand values including all-ones.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, and shift registers=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and sum/cout SHALL read 0.
REQ-028 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge at which rst_n is sampled high.

Verification
REQ-029 WIDTH=8; a=0x3C, b=0x0F, cin=0; start pulsed one cycle -> busy high for 8 cycles, then done one cycle with sum=0x4B, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 start held high continuously, with operands changed every cycle -> results appear every 9 cycles; each result matches the operands sampled at its accepting edge; start edges during RUN are ignored.
REQ-032 Operation running, rst_n pulsed low at bit 4 -> busy, done, sum, cout go to 0 without waiting for a clock edge; no done pulse follows; the next start yields a correct result.
REQ-033 Random regression of 1000 operations with a, b, cin random -> every {cout,sum} equals a+b+cin, with done exactly 8 edges after each accepting edge.
